// File: rtl/simple_io_axil_slave.sv
// simple_io_axil_slave: AXI4-Lite register file for mySimpleIO.
// CTRL/DOUT/DIN/SCRATCH at 0x0/0x4/0x8/0xC driving and sampling GPIO.
module simple_io_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int IO_WIDTH           = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [IO_WIDTH-1:0]             gpio_in,
    output logic [IO_WIDTH-1:0]             gpio_out
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_DATA } rstate_e;

    wstate_e       wstate_q, wstate_d;
    rstate_e       rstate_q, rstate_d;
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [SW-1:0] strb_q, strb_d;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] ctrl_q, ctrl_d, dout_q, dout_d, scratch_q, scratch_d;
    logic [IO_WIDTH-1:0] sync1_q, sync2_q, gpio_out_q, gpio_out_d;
    logic [DW-1:0] din;
    logic [DW-1:0] rd_mux;
    logic          aw_hs, w_hs, ar_hs;
    logic          unused_ok;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] data,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign din       = DW'(sync2_q);
    assign aw_hs     = s00_axi_awvalid & awready_q;
    assign w_hs      = s00_axi_wvalid & wready_q;
    assign ar_hs     = s00_axi_arvalid & arready_q;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr, s00_axi_araddr};

    // AW and W latch independently; commit as soon as both are present.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        addr_d    = aw_hs ? s00_axi_awaddr[3:2] : addr_q;
        data_d    = w_hs ? s00_axi_wdata : data_q;
        strb_d    = w_hs ? s00_axi_wstrb : strb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        dout_d    = dout_q;
        scratch_d = scratch_q;
        unique case (wstate_q)
            W_IDLE: begin
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    wstate_d  = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = (addr_d == 2'd2) ? 2'b10 : 2'b00;
                    case (addr_d)
                        2'd0:    ctrl_d    = merge(ctrl_q, data_d, strb_d);
                        2'd1:    dout_d    = merge(dout_q, data_d, strb_d);
                        2'd3:    scratch_d = merge(scratch_q, data_d, strb_d);
                        default: ;
                    endcase
                end
            end
            W_RESP: begin
                if (bvalid_q && s00_axi_bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        case (s00_axi_araddr[3:2])
            2'd0:    rd_mux = ctrl_q;
            2'd1:    rd_mux = dout_q;
            2'd2:    rd_mux = din;
            default: rd_mux = scratch_q;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rstate_d  = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_mux;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rstate_d  = R_IDLE;
                    arready_d = 1'b1;
                    rvalid_d  = 1'b0;
                end
            end
        endcase
    end

    assign gpio_out_d = ctrl_q[0] ? dout_q[IO_WIDTH-1:0] : '0;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            dout_q     <= '0;
            scratch_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            gpio_out_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            dout_q     <= dout_d;
            scratch_q  <= scratch_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            gpio_out_q <= gpio_out_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign gpio_out        = gpio_out_q;

endmodule
